// File: rtl/vx_hamming_pkg.sv
// Shared definitions for the SECDED (137,128) code used on the cache data
// arrays: code geometry, error classification and the data<->position map
// that both the encoder and the decoder rely on.
package vx_hamming_pkg;

  localparam int DATA_BITS    = 128;
  localparam int HAMMING_BITS = 8;
  localparam int ENCODED_BITS = DATA_BITS + HAMMING_BITS + 1;
  localparam int ERR_POS_BITS = 8;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_SEC  = 2'd1,
    ERR_DED  = 2'd2
  } err_kind_e;

  // Check bits live at power-of-two codeword positions.
  function automatic logic is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // Codeword position of data bit idx. Data fills positions 3, 5, 6, 7, 9, ...
  // skipping every power of two; each power of two at or below the running
  // position pushes the data bit up by one.
  function automatic int unsigned data_pos(input int unsigned idx);
    int unsigned pos;
    pos = idx + 1;
    for (int k = 0; k < HAMMING_BITS; k++) begin
      if ((32'd1 << k) <= pos) pos = pos + 1;
    end
    return pos;
  endfunction

endpackage

// File: rtl/vx_hamming_if.sv
// Read-path bundle between the data array, the decoder and the cache
// pipeline: codeword in with valid/ready, corrected word out with valid/ready.
interface vx_hamming_if
  import vx_hamming_pkg::*;
#(
  parameter int TAG_WIDTH = 8
) ();

  logic                    in_valid;
  logic                    in_ready;
  logic [ENCODED_BITS-1:0] in_code;
  logic [TAG_WIDTH-1:0]    in_tag;

  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_BITS-1:0]    out_data;
  logic [TAG_WIDTH-1:0]    out_tag;
  logic                    out_sec;
  logic                    out_ded;
  logic [ERR_POS_BITS-1:0] out_err_pos;

  // Side that presents codewords and consumes decoded words.
  modport master (
    output in_valid, in_code, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_sec, out_ded, out_err_pos
  );

  // Decoder side.
  modport slave (
    input  in_valid, in_code, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_sec, out_ded, out_err_pos
  );

endinterface

// File: rtl/vx_hamming_syndrome.sv
// Combinational syndrome and overall-parity generator for one codeword.
// Syndrome bit p is the XOR of every position whose index has bit p set;
// the overall parity covers all positions including bit 0.
module vx_hamming_syndrome
  import vx_hamming_pkg::*;
(
  input  logic [ENCODED_BITS-1:0] code,
  output logic [HAMMING_BITS-1:0] syn,
  output logic                    par
);

  function automatic logic [ENCODED_BITS-1:0] syn_mask(input int p);
    logic [ENCODED_BITS-1:0] m;
    m = '0;
    for (int j = 1; j < ENCODED_BITS; j++) m[j] = ((j >> p) & 1) != 0;
    return m;
  endfunction

  // One XOR tree per check bit over a constant position mask.
  for (genvar p = 0; p < HAMMING_BITS; p++) begin : g_syn
    localparam logic [ENCODED_BITS-1:0] MASK = syn_mask(p);
    assign syn[p] = ^(code & MASK);
  end

  assign par = ^code;

endmodule

// File: rtl/vx_hamming_dec.sv
// SECDED decode-and-correct stage for the cache read path.
// S1 registers the codeword with its syndrome and overall parity; S2
// classifies, corrects a single flipped position and extracts the data.
// Both stages form an elastic pipeline (1 word/cycle, 2-cycle latency);
// the only combinational path is out_ready -> in_ready.
// Build option: define VX_HAMMING_ERR_CNT_EN to include the saturating
// SEC/DED counters and cnt_clear; otherwise the counts read as zero.
module vx_hamming_dec
  import vx_hamming_pkg::*;
#(
  parameter int TAG_WIDTH   = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  vx_hamming_if.slave            bus,
  input  logic                   cnt_clear,
  output logic [COUNT_WIDTH-1:0] sec_count,
  output logic [COUNT_WIDTH-1:0] ded_count
);

  logic                    s1_valid;
  logic [ENCODED_BITS-1:0] s1_code;
  logic [TAG_WIDTH-1:0]    s1_tag;
  logic [HAMMING_BITS-1:0] s1_syn;
  logic                    s1_par;

  logic                    s2_valid;
  logic [DATA_BITS-1:0]    s2_data;
  logic [TAG_WIDTH-1:0]    s2_tag;
  logic                    s2_sec;
  logic                    s2_ded;
  logic [ERR_POS_BITS-1:0] s2_err_pos;

  logic                    s1_adv;
  logic                    s2_adv;
  logic [HAMMING_BITS-1:0] in_syn;
  logic                    in_par;

  err_kind_e               kind;
  logic [ENCODED_BITS-1:0] flip;
  logic [ENCODED_BITS-1:0] corr;
  logic [DATA_BITS-1:0]    data_x;
  logic [ERR_POS_BITS-1:0] err_pos;

  assign s2_adv       = !s2_valid || bus.out_ready;
  assign s1_adv       = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv;

  vx_hamming_syndrome u_syndrome (
    .code (bus.in_code),
    .syn  (in_syn),
    .par  (in_par)
  );

  // S1: capture codeword, tag, syndrome and parity when the stage advances.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_tag   <= '0;
      s1_syn   <= '0;
      s1_par   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_code <= bus.in_code;
        s1_tag  <= bus.in_tag;
        s1_syn  <= in_syn;
        s1_par  <= in_par;
      end
    end
  end

  // Classify the S1 word and build the single-position correction mask.
  // A syndrome beyond the last position with odd parity cannot be a single
  // error, so it is reported as uncorrectable and left untouched.
  always_comb begin
    kind    = ERR_NONE;
    flip    = '0;
    err_pos = '0;
    if (s1_par) begin
      if (s1_syn == '0) begin
        kind = ERR_SEC;
      end else if (s1_syn <= 8'(ENCODED_BITS - 1)) begin
        kind         = ERR_SEC;
        flip[s1_syn] = 1'b1;
        err_pos      = s1_syn;
      end else begin
        kind = ERR_DED;
      end
    end else if (s1_syn != '0) begin
      kind = ERR_DED;
    end
  end

  assign corr = s1_code ^ flip;

  for (genvar i = 0; i < DATA_BITS; i++) begin : g_extract
    localparam int unsigned POS = data_pos(i);
    assign data_x[i] = corr[POS];
  end

  // Parity/check positions carry no payload once corrected.
  logic [HAMMING_BITS:0] unused_chk_bits;
  assign unused_chk_bits[0] = corr[0];
  for (genvar p = 0; p < HAMMING_BITS; p++) begin : g_chk
    localparam int CPOS = 1 << p;
    assign unused_chk_bits[p+1] = corr[CPOS];
  end

  // S2: register the corrected word and its status; held while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid   <= 1'b0;
      s2_data    <= '0;
      s2_tag     <= '0;
      s2_sec     <= 1'b0;
      s2_ded     <= 1'b0;
      s2_err_pos <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data    <= data_x;
        s2_tag     <= s1_tag;
        s2_sec     <= (kind == ERR_SEC);
        s2_ded     <= (kind == ERR_DED);
        s2_err_pos <= err_pos;
      end
    end
  end

  assign bus.out_valid   = s2_valid;
  assign bus.out_data    = s2_data;
  assign bus.out_tag     = s2_tag;
  assign bus.out_sec     = s2_sec;
  assign bus.out_ded     = s2_ded;
  assign bus.out_err_pos = s2_err_pos;

`ifdef VX_HAMMING_ERR_CNT_EN
  logic                   out_fire;
  logic [COUNT_WIDTH-1:0] sec_cnt;
  logic [COUNT_WIDTH-1:0] ded_cnt;

  assign out_fire = s2_valid && bus.out_ready;

  // Count each delivered word once; clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sec_cnt <= '0;
      ded_cnt <= '0;
    end else if (cnt_clear) begin
      sec_cnt <= '0;
      ded_cnt <= '0;
    end else if (out_fire) begin
      if (s2_sec && (sec_cnt != '1)) sec_cnt <= sec_cnt + COUNT_WIDTH'(1);
      if (s2_ded && (ded_cnt != '1)) ded_cnt <= ded_cnt + COUNT_WIDTH'(1);
    end
  end

  assign sec_count = sec_cnt;
  assign ded_count = ded_cnt;
`else
  logic unused_cnt_clear;
  assign unused_cnt_clear = cnt_clear;
  assign sec_count        = '0;
  assign ded_count        = '0;
`endif

endmodule
